mod_reg16_4to16: RTL and testbench

MOD_REG16_4TO16 -- requirements
Module: mod_reg16_4to16

---
 rtl/aes_pkg.sv | 13 +
 rtl/mod_reg16_4to16.sv | 75 +++++++
 tb/tb_mod_reg16_4to16.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared byte/word/block types for the AES datapath blocks.
// Holds no logic, so it adds no latency.
// Used by both the block splitter and the word collector.
package aes_pkg;

  localparam int N     = 16;  // bytes per block
  localparam int NCOLS = 4;   // bytes per word

  typedef logic [7:0]        byte_t;
  typedef byte_t [NCOLS-1:0] word_t;
  typedef byte_t [N-1:0]     block_t;

endpackage

// File: rtl/mod_reg16_4to16.sv
// Collects four 4-byte words into one 16-byte block (inverse of the 16-to-4 splitter).
// Latency: block valid the cycle after the edge that takes the 4th word; 1 block per 5 cycles.
// Backpressure: in_ready = !reg_full; a full block is held until the out_valid/out_ready handshake.
module mod_reg16_4to16
  import aes_pkg::*;
#(
  parameter int N     = aes_pkg::N,
  parameter int NCOLS = aes_pkg::NCOLS
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [NCOLS-1:0][7:0] in_data,
  output logic                  in_ready,
  output logic [N-1:0][7:0]     o,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            n_wr,
  output logic                  reg_full
);

  localparam int NWORDS = N / NCOLS;

  byte_t [N-1:0] blk;
  logic  [1:0]   cnt;
  logic          full;
  logic          accept;
  logic          take;

  // Handshakes: a word only lands while not full, a block only leaves while full,
  // so the two can never happen on the same edge.
  always_comb begin
    accept = in_valid && !full;
    take   = full && out_ready;
  end

  // Word counter, full flag and assembly storage; clr wins over any handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= 2'd0;
      full <= 1'b0;
      blk  <= '0;
    end else if (clr) begin
      cnt  <= 2'd0;
      full <= 1'b0;
      blk  <= '0;
    end else if (accept) begin
      for (int w = 0; w < NWORDS; w++) begin
        if (cnt == w[1:0]) begin
          for (int k = 0; k < NCOLS; k++) begin
            blk[w*NCOLS + k] <= in_data[k];
          end
        end
      end
      cnt <= cnt + 2'd1;
      if (cnt == 2'(NWORDS - 1)) begin
        full <= 1'b1;
      end
    end else if (take) begin
      full <= 1'b0;
    end
  end

  // Outputs come straight from registered state, so in_ready never looks at
  // in_valid or out_ready and o cannot change while the block is held.
  always_comb begin
    in_ready  = !full;
    out_valid = full;
    reg_full  = full;
    n_wr      = cnt;
    o         = blk;
  end

endmodule

// File: tb/tb_mod_reg16_4to16.sv
// Bench for the 4-to-16 word collector: directed vectors plus a scoreboard.
// Stimulus pushes each expected block; a negedge monitor pops on every output handshake.
// The round-trip part splits random blocks into words exactly as the splitter does.
module tb_mod_reg16_4to16;
  import aes_pkg::*;

  logic         clk;
  logic         resetn;
  logic         clr;
  logic         in_valid;
  word_t        in_data;
  logic         in_ready;
  block_t       o;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   n_wr;
  logic         reg_full;

  int           n_cmp = 0;
  int           n_err = 0;
  int           ticks = 0;
  int           pushes = 0;
  int           hs = 0;
  logic [127:0] exp_q[$];

  mod_reg16_4to16 #(.N(16), .NCOLS(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .o         (o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n_wr      (n_wr),
    .reg_full  (reg_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are read 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    ticks++;
  endtask

  // Offer one word and hold it until an edge at which the block was ready.
  task automatic put(input logic [31:0] w);
    bit ok;
    bit rdy;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 20 && !ok; i++) begin
      rdy = in_ready;
      tick();
      ok = rdy;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL put_timeout: word %h never accepted", w);
    end
  endtask

  task automatic expect_block(input logic [127:0] b);
    exp_q.push_back(b);
    pushes++;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Scoreboard monitor: a handshake happens at the next edge, so compare now.
  always @(negedge clk) begin
    if (resetn && !clr && out_valid && out_ready) begin
      hs++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got block %h with nothing expected", o);
      end else begin
        check("sb_block", o, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] blk;
    logic [127:0] held;
    int           t0;
    logic [1:0]   nexp;

    resetn    = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();

    // Reset values while resetn is held low.
    check("rst_n_wr", n_wr, 0);
    check("rst_full", reg_full, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_o", o, 0);
    resetn = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);

    // Basic fill, out_ready low.
    expect_block(128'h0F0E0D0C_0B0A0908_07060504_03020100);
    put(32'h03020100);
    put(32'h07060504);
    put(32'h0B0A0908);
    check("fill_n_wr3", n_wr, 3);
    check("fill_valid3", out_valid, 0);
    put(32'h0F0E0D0C);
    check("fill_out_valid", out_valid, 1);
    check("fill_full", reg_full, 1);
    check("fill_in_ready", in_ready, 0);
    check("fill_n_wr", n_wr, 0);
    check("fill_o", o, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

    // Backpressure: extra word offered while full is ignored.
    held     = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_o", o, held);
      check("bp_n_wr", n_wr, 0);
      check("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_out_valid", out_valid, 0);
    check("bp_in_ready", in_ready, 1);
    check("bp_n_wr_after", n_wr, 0);

    // Gaps of two idle cycles between words.
    expect_block(128'h1F1E1D1C_1B1A1918_17161514_13121110);
    for (int w = 0; w < 4; w++) begin
      blk = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
      put(blk[32*w +: 32]);
      nexp = 2'(w + 1);
      check("gap_n_wr", n_wr, nexp);
      check("gap_out_valid", out_valid, (w == 3) ? 1 : 0);
      if (w < 3) begin
        tick();
        tick();
        check("gap_hold", n_wr, nexp);
        check("gap_hold_valid", out_valid, 0);
      end
    end
    consume();
    check("gap_drained", out_valid, 0);

    // Clear aborts a partial block and drops the word presented with it.
    put(32'h11111111);
    put(32'h22222222);
    check("clr_pre_n_wr", n_wr, 2);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h33333333;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_n_wr", n_wr, 0);
    check("clr_out_valid", out_valid, 0);
    expect_block(128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0);
    put(32'hA3A2A1A0);
    put(32'hA7A6A5A4);
    put(32'hABAAA9A8);
    put(32'hAFAEADAC);
    check("clr_block_valid", out_valid, 1);
    consume();

    // Asynchronous reset in the middle of a cycle with three words stored.
    put(32'h44444444);
    put(32'h55555555);
    put(32'h66666666);
    check("ar_pre_n_wr", n_wr, 3);
    #2;
    resetn = 1'b0;
    #1;
    check("ar_n_wr", n_wr, 0);
    check("ar_full", reg_full, 0);
    check("ar_out_valid", out_valid, 0);
    check("ar_o", o, 0);
    #3;
    resetn = 1'b1;
    tick();
    check("ar_in_ready", in_ready, 1);
    expect_block(128'h7F7E7D7C_7B7A7978_77767574_73727170);
    put(32'h73727170);
    put(32'h77767574);
    put(32'h7B7A7978);
    put(32'h7F7E7D7C);
    check("ar_block_valid", out_valid, 1);
    consume();

    // Round trip through the splitter's word order, continuous valid/ready.
    t0        = ticks;
    out_ready = 1'b1;
    for (int it = 0; it < 100; it++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      expect_block(blk);
      for (int w = 0; w < 4; w++) begin
        put(blk[32*w +: 32]);
      end
    end
    tick();
    out_ready = 1'b0;
    check("rt_cycles", 128'(ticks - t0), 128'd500);
    check("rt_drained", out_valid, 0);

    tick();
    check("sb_empty", 128'(exp_q.size()), 0);
    check("sb_handshakes", 128'(hs), 128'(pushes));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
